// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for multicycle_alu.
// ST_CALC exists only when ALU_MULDIV_EN is defined.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_SLL   = 4'b0100,
    OP_SLT   = 4'b0101,
    OP_XOR   = 4'b0110,
    OP_SRL   = 4'b0111,
    OP_MUL   = 4'b1000,
    OP_DIVU  = 4'b1001,
    OP_REMU  = 4'b1010,
    OP_MULHU = 4'b1011
  } aluop_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1
`ifdef ALU_MULDIV_EN
    , ST_CALC = 2'd2
`endif
  } alu_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider sharing one accumulator pair.
// lo holds product-low / quotient, hi holds product-high / remainder; both valid while done=1.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  aluop_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNTW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             isDiv_q, isDiv_d;
  logic             busy_q, busy_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [WIDTH:0]   addSum, remShift, remDiff;

  assign addSum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? operand_q : {WIDTH{1'b0}})};
  assign remShift = {acc_q, mq_q[WIDTH-1]};
  assign remDiff  = remShift - {1'b0, operand_q};

  // One iteration per cycle; done fires on the WIDTH-th step with its results on lo/hi.
  always_comb begin
    acc_d     = acc_q;
    mq_d      = mq_q;
    operand_d = operand_q;
    isDiv_d   = isDiv_q;
    busy_d    = busy_q;
    count_d   = count_q;
    done      = 1'b0;
    if (start) begin
      acc_d     = '0;
      mq_d      = a;
      operand_d = b;
      isDiv_d   = (op == OP_DIVU) || (op == OP_REMU);
      busy_d    = 1'b1;
      count_d   = '0;
    end else if (busy_q) begin
      if (isDiv_q) begin
        if (!remDiff[WIDTH]) begin
          acc_d = remDiff[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = remShift[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        {acc_d, mq_d} = {addSum, mq_q[WIDTH-1:1]};
      end
      count_d = count_q + 1'b1;
      if (&count_q) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      mq_q      <= '0;
      operand_q <= '0;
      isDiv_q   <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      operand_q <= operand_d;
      isDiv_q   <= isDiv_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
    end
  end

  assign lo = mq_d;
  assign hi = acc_d;

endmodule

// File: rtl/multicycle_alu.sv
// Valid/ready ALU: single-cycle ops complete next cycle; mul/mulhu/divu/remu iterate
// for WIDTH cycles and exist only when ALU_MULDIV_EN is defined.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, lt_q, lt_d, illegal_q, illegal_d;
  logic             accept, sltBit, quickIllegal;
  logic [WIDTH-1:0] diff, quickResult;

`ifdef ALU_MULDIV_EN
  logic             iterOp, mdStart, mdDone, selHi_q, selHi_d;
  logic [WIDTH-1:0] mdLo, mdHi, mdResult;

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (mdStart),
    .op    (aluop_t'(alucontrol)),
    .a     (a),
    .b     (b),
    .done  (mdDone),
    .lo    (mdLo),
    .hi    (mdHi)
  );

  assign mdResult = selHi_q ? mdHi : mdLo;
`endif

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);

  // Signed compare taken from a-b with the overflow correction applied.
  assign diff   = a - b;
  assign sltBit = diff[WIDTH-1] ^ ((a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]));

  always_comb begin
    quickResult  = '0;
    quickIllegal = 1'b0;
`ifdef ALU_MULDIV_EN
    iterOp       = 1'b0;
`endif
    case (alucontrol)
      OP_ADD: quickResult = a + b;
      OP_SUB: quickResult = diff;
      OP_AND: quickResult = a & b;
      OP_OR:  quickResult = a | b;
      OP_SLL: quickResult = a << b[SHW-1:0];
      OP_SLT: quickResult = {{(WIDTH-1){1'b0}}, sltBit};
      OP_XOR: quickResult = a ^ b;
      OP_SRL: quickResult = a >> b[SHW-1:0];
`ifdef ALU_MULDIV_EN
      OP_MUL, OP_MULHU: iterOp = 1'b1;
      OP_DIVU: if (b == '0) quickResult = '1; else iterOp = 1'b1;
      OP_REMU: if (b == '0) quickResult = a;  else iterOp = 1'b1;
`endif
      default: quickIllegal = 1'b1;
    endcase
  end

  // Accepting from DONE takes priority over the plain DONE->IDLE drain.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    lt_d      = lt_q;
    illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
    mdStart   = 1'b0;
    selHi_d   = selHi_q;
`endif
    if (accept) begin
      lt_d = sltBit;
`ifdef ALU_MULDIV_EN
      selHi_d = alucontrol[1];
      if (iterOp) begin
        state_d   = ST_CALC;
        mdStart   = 1'b1;
        illegal_d = 1'b0;
      end else
`endif
      begin
        state_d   = ST_DONE;
        result_d  = quickResult;
        zero_d    = (quickResult == '0);
        illegal_d = quickIllegal;
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_d = ST_IDLE;
`ifdef ALU_MULDIV_EN
    end else if ((state_q == ST_CALC) && mdDone) begin
      state_d  = ST_DONE;
      result_d = mdResult;
      zero_d   = (mdResult == '0);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      selHi_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      lt_q      <= lt_d;
      illegal_q <= illegal_d;
`ifdef ALU_MULDIV_EN
      selHi_q   <= selHi_d;
`endif
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign lt      = lt_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32): directed literal cases plus random
// traffic checked every cycle against a latency/result model; honours ALU_MULDIV_EN.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  alucontrol = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero, lt, illegal;

  int checks = 0;
  int errors = 0;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alucontrol (alucontrol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .lt         (lt),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: result, illegal flag and cycles from acceptance to out_valid.
  function automatic void refOp(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill, output int lat);
    logic [63:0] p;
    r = '0; ill = 1'b0; lat = 1;
    p = 64'(x) * 64'(y);
    case (op)
      4'd0: r = x + y;
      4'd1: r = x - y;
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x << y[4:0];
      4'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: r = x ^ y;
      4'd7: r = x >> y[4:0];
`ifdef ALU_MULDIV_EN
      4'd8:  begin r = p[31:0];  lat = 33; end
      4'd11: begin r = p[63:32]; lat = 33; end
      4'd9:  if (y == 0) r = 32'hFFFFFFFF; else begin r = x / y; lat = 33; end
      4'd10: if (y == 0) r = x;            else begin r = x % y; lat = 33; end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  bit          mStarted = 0, mHave = 0, mPending = 0, mCleared = 0;
  int          mCount = 0;
  logic [31:0] mRes = '0;
  logic        mZero = 0, mLt = 0, mIll = 0;

  function automatic bit expInReady();
    return (!mPending && !mHave) || (mHave && out_ready);
  endfunction

  // Model: one outstanding op, a countdown to its result, and the held output.
  always @(posedge clk) begin
    bit acc;
    int lat;
    logic [31:0] r;
    logic ill;
    if (reset) begin
      mStarted = 1; mHave = 0; mPending = 0; mCount = 0; mCleared = 1;
      mRes = '0; mZero = 0; mLt = 0; mIll = 0;
    end else if (mStarted) begin
      acc = in_valid && expInReady();
      if (mHave && out_ready) mHave = 0;
      if (mPending) begin
        mCount--;
        if (mCount == 0) begin mPending = 0; mHave = 1; end
      end
      if (acc) begin
        refOp(alucontrol, a, b, r, ill, lat);
        mRes = r; mIll = ill; mZero = (r == 0);
        mLt = ($signed(a) < $signed(b));
        mCleared = 0;
        if (lat == 1) mHave = 1;
        else begin mPending = 1; mCount = lat - 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (mStarted && !reset) begin
      checkOutput("in_ready", in_ready, expInReady());
      checkOutput("out_valid", out_valid, mHave);
      if (mHave || mCleared) begin
        checkOutput("result", result, mRes);
        checkOutput("zero", zero, mZero);
        checkOutput("lt", lt, mLt);
        checkOutput("illegal", illegal, mIll);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] opA, input logic [31:0] opB);
    in_valid = 1'b1; alucontrol = op; a = opA; b = opB;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; alucontrol = 4'($urandom_range(0, 15));
  endtask

  task automatic runDirected(input string name, input logic [3:0] op, input logic [31:0] opA,
                             input logic [31:0] opB, input logic [31:0] expRes, input logic expZero,
                             input logic expLt, input logic expIll, input int expLat);
    int cyc;
    out_ready = 1'b0;
    applyStimulus(op, opA, opB);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({name, "_lat"}, cyc, expLat);
    checkOutput({name, "_result"}, result, expRes);
    checkOutput({name, "_zero"}, zero, expZero);
    checkOutput({name, "_lt"}, lt, expLt);
    checkOutput({name, "_illegal"}, illegal, expIll);
  endtask

  task automatic releaseOutput();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_flags", {zero, lt, illegal}, 3'b000);

    runDirected("add", 4'b0000, 32'd7, 32'd5, 32'd12, 0, 0, 0, 1);          releaseOutput();
    runDirected("sub", 4'b0001, 32'd5, 32'd5, 32'd0, 1, 0, 0, 1);           releaseOutput();
    runDirected("slt", 4'b0101, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 1, 0, 1);    releaseOutput();
    runDirected("srl", 4'b0111, 32'h80000000, 32'h21, 32'h40000000, 0, 1, 0, 1); releaseOutput();
`ifdef ALU_MULDIV_EN
    runDirected("mul", 4'b1000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 0, 1, 0, 33); releaseOutput();
    runDirected("mulhu", 4'b1011, 32'hFFFFFFFF, 32'd2, 32'h1, 0, 1, 0, 33);     releaseOutput();
    runDirected("divu", 4'b1001, 32'd100, 32'd7, 32'd14, 0, 0, 0, 33);          releaseOutput();
    runDirected("remu", 4'b1010, 32'd100, 32'd7, 32'd2, 0, 0, 0, 33);           releaseOutput();
    runDirected("divu0", 4'b1001, 32'd100, 32'd0, 32'hFFFFFFFF, 0, 0, 0, 1);    releaseOutput();
    runDirected("remu0", 4'b1010, 32'd100, 32'd0, 32'd100, 0, 0, 0, 1);         releaseOutput();
`else
    runDirected("mul_off", 4'b1000, 32'd7, 32'd5, 32'd0, 1, 0, 1, 1);           releaseOutput();
`endif
    runDirected("illegal", 4'b1100, 32'd3, 32'd4, 32'd0, 1, 1, 1, 1);           releaseOutput();

    // Backpressure, then a back-to-back accept on the releasing cycle.
    runDirected("hold", 4'b0000, 32'd10, 32'd20, 32'd30, 0, 1, 0, 1);
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("hold_in_ready", in_ready, 0);
    checkOutput("hold_valid", out_valid, 1);
    checkOutput("hold_result", result, 32'd30);
    out_ready = 1'b1; in_valid = 1'b1; alucontrol = 4'b0110; a = 32'h0000F0F0; b = 32'h00000FF0;
    #1 checkOutput("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("b2b_valid", out_valid, 1);
    checkOutput("b2b_result", result, 32'h0000FF00);
    releaseOutput();

    // Reset partway through a multiply.
    out_ready = 1'b1;
    applyStimulus(4'b1000, 32'd3, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_valid", out_valid, 0);
    checkOutput("abort_ready", in_ready, 1);
    checkOutput("abort_result", result, 0);
    repeat (40) begin @(posedge clk); #1; end
    checkOutput("abort_quiet", out_valid, 0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset      = ($urandom_range(0, 299) == 0);
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
      alucontrol = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin a = $urandom_range(0, 20); b = $urandom_range(0, 20); end
        1: begin a = $urandom; b = $urandom; end
        2: begin a = $urandom; b = 32'd0; end
        default: begin a = 32'h80000000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h7FFFFFFF; end
      endcase
    end
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (>=8, power of two).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have ports a, b  input  WIDTH  operands, captured on acceptance.
REQ-007 SHALL have port alucontrol  input  4  opcode, captured on acceptance.
REQ-008 SHALL have port out_valid  output  1  result/flags valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port result  output  WIDTH  registered result.
REQ-011 SHALL have ports zero, lt, illegal  output  1 each  result==0; signed a<b; unsupported opcode.

Function
REQ-012 SHALL accept a request when in_valid && in_ready; in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-013 SHALL implement states IDLE, CALC, DONE: IDLE->DONE (1-cycle op), IDLE->CALC (iterative op), CALC->DONE after WIDTH iterations, DONE->IDLE on out_ready without new accept, DONE->DONE/CALC on out_ready with simultaneous accept.
REQ-014 SHALL decode 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 slt (signed, zero-extended 0/1), 0110 xor, 0111 srl, 1000 mul (low WIDTH bits), 1001 divu, 1010 remu, 1011 mulhu (high WIDTH bits, unsigned).
REQ-015 SHALL use shift amount b[$clog2(WIDTH)-1:0]; add/sub wrap modulo 2^WIDTH.
REQ-016 SHALL assert out_valid the cycle after acceptance for opcodes 0000-0111 and for divide-by-zero.
REQ-017 SHALL assert out_valid exactly WIDTH+1 cycles after acceptance for mul/mulhu/divu/remu with b!=0 (radix-2 shift-add, restoring division).
REQ-018 SHALL return all-ones for divu by zero and a for remu by zero, without iterating.
REQ-019 SHALL treat opcodes 1100-1111 as illegal: 1-cycle completion, result 0, illegal=1.
REQ-020 SHALL compute lt as signed a<b using overflow-corrected a-b, for every opcode; zero from final result.
REQ-021 SHALL hold result, zero, lt, illegal stable while out_valid && !out_ready.
REQ-022 SHALL ignore in_valid while in_ready=0; operand changes during CALC do not affect the result.

Reset
REQ-023 SHALL on reset go to IDLE, drive out_valid=0, result=0, zero=0, lt=0, illegal=0, clear iteration counter and accumulators.
REQ-024 SHALL abort any in-flight operation on reset, no output produced; in_ready=1 the cycle after reset deasserts.

Configuration
REQ-025 SHALL compile mul/mulhu/divu/remu and the CALC state only when macro ALU_MULDIV_EN is defined.
REQ-026 SHALL without ALU_MULDIV_EN treat 1000-1011 as illegal per REQ-019; no iterative logic synthesised.

Structure
REQ-027 SHALL place the opcode enum (aluop_t), state enum (alu_state_t) and opcode constants in shared package alu_pkg.
REQ-028 SHALL implement iterative mul/div in one sub-module muldiv_iter (start, op, a, b -> done, lo, hi) with a shared WIDTH-bit accumulator, instantiated only under ALU_MULDIV_EN.

Verification (WIDTH=32, ALU_MULDIV_EN defined unless stated)
REQ-029 SHALL cover add 7+5 -> result 12, zero=0, out_valid one cycle after accept; sub 5-5 -> 0, zero=1.
REQ-030 SHALL cover slt a=0xFFFFFFFF, b=1 -> result 1, lt=1; srl 0x80000000 by b=0x21 -> 0x40000000.
REQ-031 SHALL cover mul/mulhu 0xFFFFFFFF*2 -> 0xFFFFFFFE / 0x00000001, out_valid exactly 33 cycles after accept.
REQ-032 SHALL cover divu/remu 100,7 -> 14 / 2 in 33 cycles; divu/remu 100,0 -> 0xFFFFFFFF / 100 in 1 cycle.
REQ-033 SHALL cover out_ready low 5 cycles -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted same cycle.
REQ-034 SHALL cover reset at cycle 10 of a mul -> next cycle IDLE, out_valid=0, in_ready=1; without ALU_MULDIV_EN opcode 1000 -> result 0, illegal=1.
